load_instruction_type: RTL and testbench
========================================

Name: load_instruction_type

Overview:
Load-data formatter in the MEM stage of the pipelined MIPS-style CPU.
- Takes the raw 32-bit word read from data memory and the load-type code of the instruction.
- Produces the value to be written back to the register file: byte, halfword or word, sign- or zero-extended.
- Output is registered, so it lines up with the MEM/WB boundary.

Parameters:
- DATA_W, 32, width of memory data and of the result.
- TYPE_W, 3, width of the load/store type code.

Ports:
- i_clk  input  1  system clock, rising-edge active.
- i_reset  input  1  asynchronous, active-high reset.
- is_load_store_type  input  3  load type code: bit2 = unsigned flag, bits1:0 = size.
- i_mem_data  input  32  raw word read from data memory; the addressed data is right-aligned in the low bits.
- o_load  output  32  formatted, extended load result, registered.

Behaviour:
- One clock domain: i_clk. Asynchronous, active-high reset on i_reset.
- Reset:
  - o_load = 32'h0000_0000 immediately on i_reset assertion, independent of the clock.
  - o_load stays at 0 while i_reset is high.
  - First update happens at the first rising i_clk edge after i_reset is released.
- Formatting is combinational from the inputs and captured into the o_load register on every rising i_clk edge.
  - Latency: exactly 1 cycle.
  - No enable and no handshake; the register updates every cycle.
- Type decode, with d = i_mem_data:
  - 3'b000 LB: o_load = {24{d[7]}, d[7:0]}, sign-extended byte.
  - 3'b001 LH: o_load = {16{d[15]}, d[15:0]}, sign-extended halfword.
  - 3'b011 LW: o_load = d, full word.
  - 3'b111 LWU: o_load = d, full word, no extension needed.
  - 3'b100 LBU: o_load = {24'h0, d[7:0]}.
  - 3'b101 LHU: o_load = {16'h0, d[15:0]}.
  - 3'b010 and 3'b110 are unused codes: o_load = d (pass-through). No X propagation, no latch.
- Bits of d above the selected size are ignored for byte and halfword types; they never affect the result.
- Sign extension uses only bit 7 (byte) or bit 15 (halfword) of d.
- Inputs that change between edges have no effect until the next rising edge; there is no glitch on o_load.
- Reset during operation: the pending result is discarded and o_load goes to 0 at once. Normal decode resumes on the first edge after release.
- X or Z on is_load_store_type is not supported; the decode must use a full case with a default.

Test Plan:
- Reset: hold i_reset high with arbitrary inputs -> o_load = 0x00000000. Release it, apply LW with 0x12345678 -> o_load = 0x12345678 one edge later.
- Signed loads:
  - LB (000) with 0x00000f81 -> 0xFFFFFF81.
  - LB with 0xFFFFFF7F -> 0x0000007F.
  - LH (001) with 0x000f8001 -> 0xFFFF8001.
  - LH with 0xFFFF7FFF -> 0x00007FFF.
- Word loads:
  - LW (011) with 0x04000001 -> 0x04000001.
  - LWU (111) with 0x80000100 -> 0x80000100.
- Unsigned loads:
  - LBU (100) with 0x00400081 -> 0x00000081.
  - LHU (101) with 0x00208001 -> 0x00008001.
- Unused codes: 110 with 0x00300230 -> 0x00300230; 010 with 0xDEADBEEF -> 0xDEADBEEF.
- Latency and async reset: change inputs every cycle and check each result appears exactly one edge later. Assert i_reset mid-cycle -> o_load drops to 0 before the next edge.

Source files
------------

// File: rtl/load_instruction_type.sv
// rtl/load_instruction_type.sv - MEM-stage load formatter: byte/half/word with sign or zero extension, registered
module load_instruction_type #(
  parameter int DATA_W = 32,
  parameter int TYPE_W = 3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [TYPE_W-1:0] is_load_store_type,
  input  logic [DATA_W-1:0] i_mem_data,
  output logic [DATA_W-1:0] o_load
);

  localparam logic [TYPE_W-1:0] LD_B  = TYPE_W'(3'b000);
  localparam logic [TYPE_W-1:0] LD_H  = TYPE_W'(3'b001);
  localparam logic [TYPE_W-1:0] LD_BU = TYPE_W'(3'b100);
  localparam logic [TYPE_W-1:0] LD_HU = TYPE_W'(3'b101);

  logic [DATA_W-1:0] load_next;

  // Word, word-unsigned and the unused codes all pass the raw word through.
  always_comb begin
    load_next = i_mem_data;
    case (is_load_store_type)
      LD_B:    load_next = {{(DATA_W-8){i_mem_data[7]}}, i_mem_data[7:0]};
      LD_H:    load_next = {{(DATA_W-16){i_mem_data[15]}}, i_mem_data[15:0]};
      LD_BU:   load_next = {{(DATA_W-8){1'b0}}, i_mem_data[7:0]};
      LD_HU:   load_next = {{(DATA_W-16){1'b0}}, i_mem_data[15:0]};
      default: load_next = i_mem_data;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) o_load <= '0;
    else         o_load <= load_next;
  end

endmodule

// File: tb/tb_load_instruction_type.sv
// tb/tb_load_instruction_type.sv - directed-vector bench for load_instruction_type
module tb_load_instruction_type;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [2:0]  is_load_store_type = 3'b000;
  logic [31:0] i_mem_data = 32'h0;
  logic [31:0] o_load;

  int errors = 0;
  int checks = 0;

  load_instruction_type dut (
    .i_clk              (i_clk),
    .i_reset            (i_reset),
    .is_load_store_type (is_load_store_type),
    .i_mem_data         (i_mem_data),
    .o_load             (o_load)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    string       tag;
    logic [2:0]  ty;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{"lb_neg",   3'b000, 32'h00000f81, 32'hFFFFFF81});
    vecs.push_back('{"lb_pos",   3'b000, 32'hFFFFFF7F, 32'h0000007F});
    vecs.push_back('{"lh_neg",   3'b001, 32'h000f8001, 32'hFFFF8001});
    vecs.push_back('{"lh_pos",   3'b001, 32'hFFFF7FFF, 32'h00007FFF});
    vecs.push_back('{"lw",       3'b011, 32'h04000001, 32'h04000001});
    vecs.push_back('{"lwu",      3'b111, 32'h80000100, 32'h80000100});
    vecs.push_back('{"lbu",      3'b100, 32'h00400081, 32'h00000081});
    vecs.push_back('{"lhu",      3'b101, 32'h00208001, 32'h00008001});
    vecs.push_back('{"unused110",3'b110, 32'h00300230, 32'h00300230});
    vecs.push_back('{"unused010",3'b010, 32'hDEADBEEF, 32'hDEADBEEF});
    vecs.push_back('{"lbu_hi",   3'b100, 32'hFFFFFFFF, 32'h000000FF});
    vecs.push_back('{"lhu_hi",   3'b101, 32'hFFFFFFFF, 32'h0000FFFF});

    // Reset with arbitrary inputs, across clock edges
    is_load_store_type = 3'b011;
    i_mem_data = 32'hCAFEF00D;
    repeat (3) @(posedge i_clk);
    #1 check("reset_hold", o_load, 32'h0);

    @(negedge i_clk);
    i_reset = 1'b0;
    is_load_store_type = 3'b011;
    i_mem_data = 32'h12345678;
    #1 check("no_update_before_edge", o_load, 32'h0);
    @(posedge i_clk);
    #1 check("first_lw", o_load, 32'h12345678);

    // Back-to-back vectors: each result must appear exactly one edge after its input
    foreach (vecs[i]) begin
      @(negedge i_clk);
      is_load_store_type = vecs[i].ty;
      i_mem_data = vecs[i].data;
      if (i > 0) check({vecs[i-1].tag, "_held"}, o_load, vecs[i-1].exp);
      @(posedge i_clk);
      #1 check(vecs[i].tag, o_load, vecs[i].exp);
    end

    // Input change between edges must not reach o_load
    @(negedge i_clk);
    is_load_store_type = 3'b000;
    i_mem_data = 32'h00000080;
    #2 i_mem_data = 32'h0000007F;
    #1 check("mid_cycle_glitch", o_load, 32'h0000FFFF);
    @(posedge i_clk);
    #1 check("mid_cycle_last_value", o_load, 32'h0000007F);

    // Asynchronous reset mid-cycle
    @(negedge i_clk);
    is_load_store_type = 3'b011;
    i_mem_data = 32'hA5A5A5A5;
    @(posedge i_clk);
    #1 check("pre_async", o_load, 32'hA5A5A5A5);
    #2 i_reset = 1'b1;
    #1 check("async_reset", o_load, 32'h0);
    @(posedge i_clk);
    #1 check("async_reset_held", o_load, 32'h0);
    @(negedge i_clk);
    i_reset = 1'b0;
    is_load_store_type = 3'b001;
    i_mem_data = 32'h1234F00F;
    @(posedge i_clk);
    #1 check("resume_lh", o_load, 32'hFFFFF00F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
